// File: rtl/pic_bus_initiator_pkg.sv
// Shared definitions for the PIC register-port initiator.
// Holds the transaction FSM encoding and the default timeout read value.
// No logic; imported by the initiator.
package pic_bus_initiator_pkg;

  // One transaction at a time: wait for a command, drive the strobe, return the response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Read data reported when the PIC never answers.
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/pic_bus_watchdog.sv
// Strobe watchdog: counts cycles while enabled and flags the TIMEOUT-th cycle.
// Latency: o_expired is combinational from the count, high during the TIMEOUT-th enabled cycle.
// Backpressure: none; the count saturates and never wraps. TIMEOUT=0 disables expiry.
module pic_bus_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);

      logic [CW-1:0] r_cnt;

      // Count completed enabled cycles; cleared when a new strobe phase starts, held at the top.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en && (r_cnt != MAX_CNT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // r_cnt cycles already elapsed, so the current one is the last allowed when r_cnt reaches TIMEOUT-1.
      assign o_expired = i_en && (r_cnt >= LAST_CNT);
    end
  endgenerate

endmodule

// File: rtl/pic_bus_initiator.sv
// Single-outstanding bus initiator driving the PIC wrapper's address/wen/ren register port.
// Latency: strobe the cycle after accept; response the cycle after ready (2 cycles minimum).
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; watchdog aborts a stuck strobe.
module pic_bus_initiator
  import pic_bus_initiator_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT      = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wen,
  output logic              bus_ren,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_bus_done;
  logic                w_in_req;
  logic                w_expired;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_timeout;

  // State register; async reset drops any strobe immediately and forgets the command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: ready and watchdog expiry both end REQ; bus_ready is only looked at in REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bus_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = cmd_valid;
        if (cmd_valid) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus_ready || w_expired) begin
          w_bus_done  = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_req = (r_state == ST_REQ);

  pic_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_accept),
    .i_en      (w_in_req),
    .o_expired (w_expired)
  );

  // Command capture on accept; response capture when REQ ends (ready takes priority over expiry).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_write <= cmd_write;
      end
      if (w_bus_done) begin
        if (bus_ready) begin
          r_rdata   <= r_write ? '0 : bus_rdata;
          r_timeout <= 1'b0;
        end else begin
          r_rdata   <= TIMEOUT_DATA;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // Handshakes and strobes decode straight from the state, so only one strobe can ever be high.
  assign cmd_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_timeout = rsp_valid && r_timeout;
  assign rsp_rdata   = r_rdata;
  assign bus_wen     = w_in_req &&  r_write;
  assign bus_ren     = w_in_req && !r_write;
  assign bus_address = r_addr;
  assign bus_wdata   = r_wdata;

endmodule
